// File: rtl/usb_data_buffer.sv
// usb_data_buffer: endpoint data FIFO shared by the RX engine, TX engine and
// AHB slave. Writers and readers each go through a fixed-priority arbiter
// (RX over AHB for stores, TX over AHB for gets). The block keeps sticky
// overflow/underflow flags, reports arbitration losses as one-cycle pulses,
// and drives an almost-full watermark. rdata is first-word fall-through.
module usb_data_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int AFULL_TH = 56,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int OCC_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              rx_store,
  input  logic [DATA_W-1:0] rx_wdata,
  input  logic              ahb_store,
  input  logic [DATA_W-1:0] ahb_wdata,
  input  logic              tx_get,
  input  logic              ahb_get,
  output logic [DATA_W-1:0] rdata,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow,
  output logic              ahb_store_drop,
  output logic              ahb_get_drop
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_AF  = OCC_W'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_next, rd_ptr_next;
  logic [OCC_W-1:0]  occ_next;
  logic [DATA_W-1:0] wdata;
  logic              store_req, get_req;
  logic              is_empty, is_full;
  logic              do_store, do_get;
  logic              ovf_next, unf_next;
  logic              sdrop_next, gdrop_next;

  assign is_empty = (buffer_occupancy == '0);
  assign is_full  = (buffer_occupancy == OCC_MAX);

  // Arbitration, grant qualification and next-state occupancy/pointers/flags.
  // A pop while full frees the slot the same-cycle store refills, so the
  // store is allowed and overflow is not raised. There is no empty bypass.
  always_comb begin
    store_req   = rx_store | ahb_store;
    get_req     = tx_get | ahb_get;
    wdata       = rx_store ? rx_wdata : ahb_wdata;
    do_get      = get_req && !is_empty;
    do_store    = store_req && (!is_full || do_get);
    ovf_next    = overflow | (store_req && is_full && !do_get);
    unf_next    = underflow | (get_req && is_empty);
    sdrop_next  = rx_store & ahb_store;
    gdrop_next  = tx_get & ahb_get;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    occ_next    = buffer_occupancy;

    if (clear) begin
      do_store    = 1'b0;
      do_get      = 1'b0;
      ovf_next    = 1'b0;
      unf_next    = 1'b0;
      sdrop_next  = 1'b0;
      gdrop_next  = 1'b0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      occ_next    = '0;
    end else begin
      if (do_store) wr_ptr_next = wr_ptr + PTR_W'(1);
      if (do_get)   rd_ptr_next = rd_ptr + PTR_W'(1);
      case ({do_store, do_get})
        2'b10:   occ_next = buffer_occupancy + OCC_W'(1);
        2'b01:   occ_next = buffer_occupancy - OCC_W'(1);
        default: occ_next = buffer_occupancy;
      endcase
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= wdata;
  end

  // Control state register; status flags are computed from occ_next so they
  // line up with buffer_occupancy in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      buffer_occupancy <= '0;
      empty            <= 1'b1;
      full             <= 1'b0;
      almost_full      <= 1'b0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
      ahb_store_drop   <= 1'b0;
      ahb_get_drop     <= 1'b0;
    end else begin
      wr_ptr           <= wr_ptr_next;
      rd_ptr           <= rd_ptr_next;
      buffer_occupancy <= occ_next;
      empty            <= (occ_next == '0);
      full             <= (occ_next == OCC_MAX);
      almost_full      <= (occ_next >= OCC_AF);
      overflow         <= ovf_next;
      underflow        <= unf_next;
      ahb_store_drop   <= sdrop_next;
      ahb_get_drop     <= gdrop_next;
    end
  end

  // Head entry, zeroed while empty so stale data never leaks out.
  always_comb begin
    rdata = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb_usb_data_buffer: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the endpoint FIFO.
module tb_usb_data_buffer;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 64;
  localparam int AFULL_TH = 56;
  localparam int OCC_W    = 7;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              clear;
  logic              rx_store, ahb_store, tx_get, ahb_get;
  logic [DATA_W-1:0] rx_wdata, ahb_wdata;
  logic [DATA_W-1:0] rdata;
  logic [OCC_W-1:0]  buffer_occupancy;
  logic              empty, full, almost_full, overflow, underflow;
  logic              ahb_store_drop, ahb_get_drop;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  bit m_ovf, m_unf, m_sdrop, m_gdrop;

  usb_data_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .rx_store(rx_store), .rx_wdata(rx_wdata),
    .ahb_store(ahb_store), .ahb_wdata(ahb_wdata),
    .tx_get(tx_get), .ahb_get(ahb_get),
    .rdata(rdata), .buffer_occupancy(buffer_occupancy),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow),
    .ahb_store_drop(ahb_store_drop), .ahb_get_drop(ahb_get_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [DATA_W-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk("occ",   32'(buffer_occupancy), 32'(q.size()));
    chk("empty", 32'(empty),       32'(q.size() == 0));
    chk("full",  32'(full),        32'(q.size() == DEPTH));
    chk("afull", 32'(almost_full), 32'(q.size() >= AFULL_TH));
    chk("ovf",   32'(overflow),    32'(m_ovf));
    chk("unf",   32'(underflow),   32'(m_unf));
    chk("sdrop", 32'(ahb_store_drop), 32'(m_sdrop));
    chk("gdrop", 32'(ahb_get_drop),   32'(m_gdrop));
    chk("rdata", 32'(rdata),       32'(head));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_sdrop = 0; m_gdrop = 0;
  endtask

  // One clock: drive, clock edge, update model, sample 1ns later, then idle.
  task automatic step(input bit rs, input bit as, input bit tg, input bit ag,
                      input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] ad,
                      input bit clr);
    bit popped;
    rx_store = rs; ahb_store = as; tx_get = tg; ahb_get = ag;
    rx_wdata = rd; ahb_wdata = ad; clear = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      popped = 0;
      if (tg || ag) begin
        if (q.size() == 0) m_unf = 1;
        else popped = 1;
      end
      if (rs || as) begin
        if (q.size() == DEPTH && !popped) m_ovf = 1;
        else begin
          if (popped) begin void'(q.pop_front()); popped = 0; end
          q.push_back(rs ? rd : ad);
        end
      end
      if (popped) void'(q.pop_front());
      m_sdrop = rs && as;
      m_gdrop = tg && ag;
    end
    #1;
    check_all();
    rx_store = 0; ahb_store = 0; tx_get = 0; ahb_get = 0; clear = 0;
  endtask

  initial begin
    n_rst = 0; clear = 0;
    rx_store = 0; ahb_store = 0; tx_get = 0; ahb_get = 0;
    rx_wdata = '0; ahb_wdata = '0;
    model_reset();
    #12;
    check_all();
    n_rst = 1;
    @(posedge clk); #1;
    check_all();

    // basic order via RX / TX
    step(1,0,0,0,8'h11,0,0);
    step(1,0,0,0,8'h22,0,0);
    step(1,0,0,0,8'h33,0,0);
    chk("t1_occ3", 32'(buffer_occupancy), 3);
    chk("t1_head", 32'(rdata), 32'h11);
    repeat (3) step(0,0,1,0,0,0,0);
    chk("t1_empty", 32'(empty), 1);

    // fill via AHB, overflow, then simultaneous store+get while full
    for (int i = 0; i < DEPTH; i++) begin
      step(0,1,0,0,0,8'(i + 8'h40),0);
      if (i == AFULL_TH - 2) chk("af_below", 32'(almost_full), 0);
      if (i == AFULL_TH - 1) chk("af_at",    32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    step(0,1,0,0,0,8'hEE,0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_occ", 32'(buffer_occupancy), 64);
    step(0,1,1,0,0,8'hC3,0);
    chk("sg_full_occ", 32'(buffer_occupancy), 64);
    chk("sg_full_head", 32'(rdata), 32'h41);
    repeat (DEPTH) step(0,0,1,0,0,0,0);

    // arbitration collisions
    step(1,1,0,0,8'hAA,8'h55,0);
    chk("coll_data", 32'(rdata), 32'hAA);
    chk("coll_sdrop", 32'(ahb_store_drop), 1);
    step(0,0,0,0,0,0,0);
    step(0,1,0,0,0,8'h66,0);
    step(0,0,1,1,0,0,0);
    chk("coll_gdrop", 32'(ahb_get_drop), 1);
    chk("coll_single", 32'(buffer_occupancy), 1);
    step(0,0,0,0,0,0,0);
    step(0,0,1,0,0,0,0);

    // underflow and no-bypass
    step(0,0,1,0,0,0,0);
    chk("unf_set", 32'(underflow), 1);
    step(1,0,1,0,8'h7E,0,0);
    chk("nobypass", 32'(rdata), 32'h7E);
    step(0,0,0,0,0,0,1);

    // wrap-around with steady occupancy
    for (int i = 0; i < 10; i++) step(1,0,0,0,8'(i),0,0);
    for (int i = 10; i < 210; i++) step(1,0,1,0,8'(i),0,0);
    chk("wrap_occ", 32'(buffer_occupancy), 10);

    // occupancy 20 with overflow, then clear beside a store
    for (int i = 0; i < DEPTH - 10 + 1; i++) step(0,1,0,0,0,8'(i),0);
    repeat (DEPTH - 20) step(0,0,0,1,0,0,0);
    chk("pre_clr_occ", 32'(buffer_occupancy), 20);
    step(1,0,0,0,8'h99,0,1);
    chk("clr_occ", 32'(buffer_occupancy), 0);
    chk("clr_ovf", 32'(overflow), 0);

    // randomized traffic with a mid-burst asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      int ps;
      ps = ((i / 250) % 2 != 0) ? 80 : 30;
      step($urandom_range(0,99) < ps, $urandom_range(0,99) < ps / 2,
           $urandom_range(0,99) < 100 - ps, $urandom_range(0,99) < (100 - ps) / 2,
           8'($urandom_range(0,255)), 8'($urandom_range(0,255)),
           $urandom_range(0,299) == 0);
      if (i == 1600) begin
        #2;
        n_rst = 0;
        #1;
        model_reset();
        check_all();
        #2;
        n_rst = 1;
        @(posedge clk); #1;
        check_all();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
